alu_share_arbiter: RTL
======================

Name: alu_share_arbiter

Overview:
- Shares one combinational 32-bit ALU (adder/subtractor, logic gates, LUI, barrel shifter) between two requesters: requester 0 is the integer execute stage and requester 1 is the address/branch-compare unit.
- Accepts one operation at a time via a valid/ready handshake and arbitrates round-robin.
- Drives registered operands and control to the ALU, waits a programmable settle time, captures the result and zero flag, and returns them to the granted requester over a response valid/ready handshake.

Parameters:
- DATA_WIDTH, 32, operand/result width.
- CTRL_WIDTH, 4, ALUC control width.
- SETTLE_CYCLES, 1, cycles operands are held on the ALU before the result is captured. Legal range is 1..15.

Ports:
- clk  input  1  single clock, rising edge.
- resetn  input  1  asynchronous, active-low reset.
- req_valid  input  2  per-requester request valid; bit i belongs to requester i.
- req_ready  output  2  per-requester request accept.
- req0_aluc  input  CTRL_WIDTH  requester 0 operation.
- req0_a  input  DATA_WIDTH  requester 0 operand A (low 5 bits are the shift amount for shifts).
- req0_b  input  DATA_WIDTH  requester 0 operand B.
- req1_aluc, req1_a, req1_b  input  as above, for requester 1.
- rsp_valid  output  2  per-requester result valid.
- rsp_ready  input  2  per-requester result accept.
- rsp_data  output  DATA_WIDTH  result; shared, qualified by rsp_valid.
- rsp_zero  output  1  result==0; shared, qualified by rsp_valid.
- alu_aluc  output  CTRL_WIDTH  control to ALU (registered).
- alu_a  output  DATA_WIDTH  operand A to ALU (registered).
- alu_b  output  DATA_WIDTH  operand B to ALU (registered).
- alu_r  input  DATA_WIDTH  ALU result (combinational from alu_*).
- busy  output  1  high whenever state is not IDLE.

Behaviour:
- Reset: state=IDLE, rr_ptr=0 (requester 0 favoured), req_ready=0, rsp_valid=0, rsp_data=0, rsp_zero=0, alu_aluc=0, alu_a=0, alu_b=0, busy=0, settle counter=0, grant register=0. Assertion mid-operation aborts immediately; any in-flight op is dropped with no response.
- States are IDLE -> EXEC -> RESP -> IDLE.
- IDLE:
  - grant = rr_ptr if req_valid[rr_ptr], else the other requester if it is valid.
  - req_ready[grant] is driven combinationally high in IDLE only; the other bit is 0.
  - On valid&ready: latch that requester's aluc/a/b into alu_*, record grant, load counter=SETTLE_CYCLES-1, go to EXEC.
  - rr_ptr <= ~grant at acceptance.
- EXEC:
  - alu_* are held stable.
  - If counter==0: capture rsp_data<=alu_r and rsp_zero<=(alu_r==0), go to RESP. Otherwise decrement.
  - With SETTLE_CYCLES=1, capture occurs on the first EXEC edge.
- RESP:
  - rsp_valid[grant]=1 and rsp_data/rsp_zero are held until rsp_ready[grant].
  - On handshake: rsp_valid returns to 0 next cycle, go to IDLE.
  - rsp_ready on the non-granted bit is ignored.
- Latency: request accept edge to rsp_valid high is SETTLE_CYCLES+1 edges. Peak throughput is one op per SETTLE_CYCLES+2 cycles. No new request is accepted in the same cycle as a response handshake.
- Simultaneous requests: the rr_ptr requester wins. A loser holding valid is guaranteed the next grant (no starvation).
- A requester must hold valid and payload stable until ready. Deasserting valid before acceptance is permitted and withdraws the request.
- alu_* keep their last values in IDLE. They are not cleared between ops.
- Unknown ALUC codes are passed through unchanged; the arbiter does not decode the operation.

Decomposition:
- Package alu_pkg holds:
  - ALUC constants: ADD=x000, SUB=x100, AND=x001, OR=x101, XOR=x010, LUI=x110, SLL=0011, SRL=0111, SRA=1111.
  - The state enum (IDLE, EXEC, RESP).
  - The requester index type.
- Sub-module rr_arbiter2: combinational 2-way round-robin pick from req_valid and rr_ptr, outputting grant and grant_valid. The pointer register stays in the parent.

Test Plan:
- Reset, then req_valid=01 with ADD a=5 b=7 and rsp_ready=1 -> rsp_valid[0] two edges after accept, rsp_data=12, rsp_zero=0; then back to IDLE.
- req_valid=11 held continuously, req0 SUB 9-9, req1 SRA a=4 b=0x80000000 -> grant order 0,1,0,1. Req0 returns data=0 with zero=1; req1 returns 0xF8000000.
- rsp_ready=0 for 5 cycles in RESP -> rsp_valid and data stay stable, req_ready=00, busy=1. Releasing rsp_ready gives one handshake, then IDLE.
- SETTLE_CYCLES=3 with XOR 0xFFFF0000^0x0F0F0F0F -> alu_* stable for 3 cycles, result 0xF0F00F0F, and rsp_valid appears 4 edges after accept.
- resetn pulsed low during EXEC -> all outputs go to reset values asynchronously, no rsp_valid afterwards, and the next request is served normally with requester 0 favoured.
- req1 asserts valid then drops it before acceptance while req0 is busy -> no grant to req1 and no spurious response.

Source files
------------

// File: rtl/alu_share_arbiter_pkg.sv
// alu_pkg: ALU control codes, arbiter state encoding and requester index type
package alu_pkg;
  localparam logic [3:0] ALUC_ADD = 4'b0000;
  localparam logic [3:0] ALUC_SUB = 4'b0100;
  localparam logic [3:0] ALUC_AND = 4'b0001;
  localparam logic [3:0] ALUC_OR  = 4'b0101;
  localparam logic [3:0] ALUC_XOR = 4'b0010;
  localparam logic [3:0] ALUC_LUI = 4'b0110;
  localparam logic [3:0] ALUC_SLL = 4'b0011;
  localparam logic [3:0] ALUC_SRL = 4'b0111;
  localparam logic [3:0] ALUC_SRA = 4'b1111;
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  typedef logic req_idx_t;
  function automatic logic [1:0] onehot(input req_idx_t i);
    return i ? 2'b10 : 2'b01;
  endfunction
endpackage

// File: rtl/alu_share_arbiter_if.sv
// alu_share_arbiter_if: request/response handshakes of both requesters
interface alu_share_arbiter_if #(parameter int DATA_WIDTH = 32, parameter int CTRL_WIDTH = 4);
  logic [1:0]            req_valid;
  logic [1:0]            req_ready;
  logic [CTRL_WIDTH-1:0] req0_aluc;
  logic [DATA_WIDTH-1:0] req0_a;
  logic [DATA_WIDTH-1:0] req0_b;
  logic [CTRL_WIDTH-1:0] req1_aluc;
  logic [DATA_WIDTH-1:0] req1_a;
  logic [DATA_WIDTH-1:0] req1_b;
  logic [1:0]            rsp_valid;
  logic [1:0]            rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_data;
  logic                  rsp_zero;
  modport master (
    output req_valid, req0_aluc, req0_a, req0_b, req1_aluc, req1_a, req1_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_zero
  );
  modport slave (
    input  req_valid, req0_aluc, req0_a, req0_b, req1_aluc, req1_a, req1_b, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_zero
  );
endinterface

// File: rtl/alu_share_arbiter_rr.sv
// rr_arbiter2: two-way round-robin pick; the pointer register lives in the parent
module rr_arbiter2
  import alu_pkg::*;
(
  input  logic [1:0] req_valid,
  input  req_idx_t   rr_ptr,
  output req_idx_t   grant,
  output logic       grant_valid
);
  assign grant       = req_valid[rr_ptr] ? rr_ptr : ~rr_ptr;
  assign grant_valid = |req_valid;
endmodule

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: time-shares one combinational ALU between two requesters,
// holding registered operands for a settle time before capturing the result.
module alu_share_arbiter
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int CTRL_WIDTH    = 4,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic                  clk,
  input  logic                  resetn,
  alu_share_arbiter_if.slave    bus,
  output logic [CTRL_WIDTH-1:0] alu_aluc,
  output logic [DATA_WIDTH-1:0] alu_a,
  output logic [DATA_WIDTH-1:0] alu_b,
  input  logic [DATA_WIDTH-1:0] alu_r,
  output logic                  busy
);
  state_t                r_state, w_next;
  req_idx_t              r_rr_ptr, r_grant, w_grant;
  logic                  w_grant_valid, w_accept, w_capture, w_rsp_hs;
  logic [3:0]            r_cnt;
  logic [CTRL_WIDTH-1:0] r_alu_aluc;
  logic [DATA_WIDTH-1:0] r_alu_a, r_alu_b, r_rsp_data;
  logic                  r_rsp_zero;

  rr_arbiter2 u_rr (
    .req_valid   (bus.req_valid),
    .rr_ptr      (r_rr_ptr),
    .grant       (w_grant),
    .grant_valid (w_grant_valid)
  );

  assign w_accept  = (r_state == IDLE) && w_grant_valid;
  assign w_capture = (r_state == EXEC) && (r_cnt == 4'd0);
  assign w_rsp_hs  = (r_state == RESP) && bus.rsp_ready[r_grant];

  always_comb begin
    w_next = r_state;
    if (w_accept) w_next = EXEC;
    else if (w_capture) w_next = RESP;
    else if (w_rsp_hs) w_next = IDLE;
  end

  always_ff @(posedge clk or negedge resetn)
    if (!resetn) r_state <= IDLE;
    else r_state <= w_next;

  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      r_rr_ptr   <= 1'b0;
      r_grant    <= 1'b0;
      r_cnt      <= 4'd0;
      r_alu_aluc <= '0;
      r_alu_a    <= '0;
      r_alu_b    <= '0;
      r_rsp_data <= '0;
      r_rsp_zero <= 1'b0;
    end else if (w_accept) begin
      r_rr_ptr   <= ~w_grant;
      r_grant    <= w_grant;
      r_cnt      <= 4'(SETTLE_CYCLES - 1);
      r_alu_aluc <= w_grant ? bus.req1_aluc : bus.req0_aluc;
      r_alu_a    <= w_grant ? bus.req1_a : bus.req0_a;
      r_alu_b    <= w_grant ? bus.req1_b : bus.req0_b;
    end else if (w_capture) begin
      r_rsp_data <= alu_r;
      r_rsp_zero <= (alu_r == '0);
    end else if (r_state == EXEC) begin
      r_cnt <= r_cnt - 4'd1;
    end

  assign bus.req_ready = w_accept ? onehot(w_grant) : 2'b00;
  assign bus.rsp_valid = (r_state == RESP) ? onehot(r_grant) : 2'b00;
  assign bus.rsp_data  = r_rsp_data;
  assign bus.rsp_zero  = r_rsp_zero;
  assign alu_aluc      = r_alu_aluc;
  assign alu_a         = r_alu_a;
  assign alu_b         = r_alu_b;
  assign busy          = (r_state != IDLE);
endmodule
